// File: rtl/adc2_cfg_pkg.sv
// Shared definitions for the ADC2 configuration sequencer: word width,
// sequencer state encoding and the default register-word table.
package adc2_cfg_pkg;

   localparam int WORD_W    = 24;
   localparam int CFG_DEPTH = 8;
   localparam int CFG_IDX_W = $clog2(CFG_DEPTH);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PWRUP,
      ST_LOAD,
      ST_SEND,
      ST_WAIT_ACK,
      ST_WAIT_DONE,
      ST_GAP,
      ST_DONE,
      ST_ERR
   } state_t;

   // Default register words: {8-bit register address, 16-bit value}.
   function automatic logic [WORD_W-1:0] cfg_word(input logic [CFG_IDX_W-1:0] idx);
      case (idx)
         3'd0:    return 24'h000080;  // soft reset
         3'd1:    return 24'h010203;
         3'd2:    return 24'h02A5C3;
         3'd3:    return 24'h031F00;
         3'd4:    return 24'h04FFFF;
         3'd5:    return 24'h058001;
         3'd6:    return 24'h06DEAD;
         default: return 24'h07BEEF;
      endcase
   endfunction

endpackage

// File: rtl/adc2_cfg_rom.sv
// Combinational lookup of the configuration word for a given index.
// Indices beyond the table return an all-zero (no-op) word.
module adc2_cfg_rom
   import adc2_cfg_pkg::*;
(
   input  logic [7:0]        idx,
   output logic [WORD_W-1:0] word
);

   // Table lookup with out-of-range guard.
   always_comb begin
      // NOTE: default assignment first so every path drives word -- no latch.
      word = '0;
      if (idx < 8'(CFG_DEPTH)) word = cfg_word(idx[CFG_IDX_W-1:0]);
   end

endmodule

// File: rtl/adc2_cfg_seq.sv
// ADC2 configuration sequencer: after a start request it waits for the
// converter to power up, then streams N_WORDS table words to the SPI
// serializer, using spi_cs as the per-word acknowledge/completion handshake.
module adc2_cfg_seq
   import adc2_cfg_pkg::*;
#(
   parameter int N_WORDS      = 8,
   parameter int PWRUP_CYCLES = 1000,
   parameter int GAP_CYCLES   = 4,
   parameter int ACK_TIMEOUT  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              spi_cs,
   output logic              send,
   output logic [WORD_W-1:0] pattern,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [7:0]        word_idx
);

   localparam int PW_W = $clog2(PWRUP_CYCLES + 1) + 1;
   localparam int GP_W = $clog2(GAP_CYCLES + 1) + 1;
   localparam int AK_W = $clog2(ACK_TIMEOUT + 1) + 1;

   // Terminal counts; only used when the matching parameter is nonzero.
   localparam logic [PW_W-1:0] PW_LAST  = PW_W'(PWRUP_CYCLES - 1);
   localparam logic [GP_W-1:0] GP_LAST  = GP_W'(GAP_CYCLES - 1);
   localparam logic [AK_W-1:0] AK_LAST  = AK_W'(ACK_TIMEOUT - 1);
   localparam logic [7:0]      LAST_IDX = 8'(N_WORDS - 1);

   state_t            state;
   logic [PW_W-1:0]   pwr_cnt;
   logic [GP_W-1:0]   gap_cnt;
   logic [AK_W-1:0]   ack_cnt;
   logic [WORD_W-1:0] rom_word;
   logic              gap_exit;

   adc2_cfg_rom u_rom (
      .idx  (word_idx),
      .word (rom_word)
   );

   // End of the inter-word gap; with no gap this is the cs-high return itself.
   always_comb begin
      gap_exit = 1'b0;
      if (state == ST_GAP)
         gap_exit = (gap_cnt == GP_LAST);
      else if (state == ST_WAIT_DONE)
         gap_exit = spi_cs && (GAP_CYCLES == 0);
   end

   // Sequencer FSM with its counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: plain flops only (the ROM holds no state), so all are reset.
         state    <= ST_IDLE;
         send     <= 1'b0;
         pattern  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         word_idx <= '0;
         pwr_cnt  <= '0;
         gap_cnt  <= '0;
         ack_cnt  <= '0;
      end else begin
         // NOTE: non-blocking throughout so every flop sees pre-edge values.
         send <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start) begin
                  state    <= ST_PWRUP;
                  word_idx <= '0;
                  done     <= 1'b0;
                  err      <= 1'b0;
                  busy     <= 1'b1;
                  pwr_cnt  <= '0;
               end
            end
            ST_PWRUP: begin
               if (PWRUP_CYCLES == 0 || pwr_cnt == PW_LAST) state <= ST_LOAD;
               else pwr_cnt <= pwr_cnt + 1'b1;
            end
            ST_LOAD: begin
               pattern <= rom_word;
               // The serializer has no reset, so a word may still be in flight.
               if (spi_cs) begin
                  state <= ST_SEND;
                  send  <= 1'b1;
               end
            end
            ST_SEND: begin
               state   <= ST_WAIT_ACK;
               ack_cnt <= '0;
            end
            ST_WAIT_ACK: begin
               if (!spi_cs) begin
                  state <= ST_WAIT_DONE;
               end else if (ACK_TIMEOUT <= 1 || ack_cnt == AK_LAST) begin
                  state <= ST_ERR;
                  busy  <= 1'b0;
                  err   <= 1'b1;
               end else begin
                  ack_cnt <= ack_cnt + 1'b1;
               end
            end
            ST_WAIT_DONE: begin
               if (spi_cs) begin
                  state   <= ST_GAP;
                  gap_cnt <= '0;
               end
            end
            ST_GAP: gap_cnt <= gap_cnt + 1'b1;
            default: state <= ST_IDLE;
         endcase

         // Gap finished: either the sequence is complete or fetch the next word.
         if (gap_exit) begin
            if (word_idx == LAST_IDX) begin
               state <= ST_DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end else begin
               state    <= ST_LOAD;
               word_idx <= word_idx + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_adc2_cfg_seq.sv
// Bench for adc2_cfg_seq: two instances (3-word/powered-up and 1-word/no-delay)
// each driving a behavioural SPI serializer. Expected words go into queues
// when a run is started; a monitor pops them as serializer words complete.
module tb_adc2_cfg_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   logic        rst = 1'b1;
   logic        start_a = 1'b0, start_b = 1'b0;
   logic        send_a, busy_a, done_a, err_a, cs_a;
   logic        send_b, busy_b, done_b, err_b, cs_b;
   logic [23:0] pattern_a, pattern_b;
   logic [7:0]  idx_a, idx_b;

   // Hand-computed register words 0..2 of the default table.
   logic [23:0] exp_rom [3] = '{24'h000080, 24'h010203, 24'h02A5C3};
   logic [23:0] exp_a [$];
   logic [23:0] exp_b [$];

   adc2_cfg_seq #(.N_WORDS(3), .PWRUP_CYCLES(10), .GAP_CYCLES(4), .ACK_TIMEOUT(4)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .spi_cs(cs_a), .send(send_a),
      .pattern(pattern_a), .busy(busy_a), .done(done_a), .err(err_a), .word_idx(idx_a)
   );

   adc2_cfg_seq #(.N_WORDS(1), .PWRUP_CYCLES(0), .GAP_CYCLES(0), .ACK_TIMEOUT(4)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .spi_cs(cs_b), .send(send_b),
      .pattern(pattern_b), .busy(busy_b), .done(done_b), .err(err_b), .word_idx(idx_b)
   );

   // Serializer models: load on send, 24 bits MSB first with cs low, no reset.
   logic        ser_en_a = 1'b1, hold_low_a = 1'b0;
   logic        cs_r_a = 1'b1, cs_r_b = 1'b1;
   logic [23:0] sh_a = '0, sh_b = '0, rx_a = '0, rx_b = '0, rx_word_a = '0, rx_word_b = '0;
   int          bits_a = 0, bits_b = 0;
   logic        rx_valid_a = 1'b0, rx_valid_b = 1'b0;

   assign cs_a = !ser_en_a ? 1'b1 : (hold_low_a ? 1'b0 : cs_r_a);
   assign cs_b = cs_r_b;

   always @(posedge clk) begin
      rx_valid_a <= 1'b0;
      if (bits_a != 0) begin
         rx_a   <= {rx_a[22:0], sh_a[23]};
         sh_a   <= sh_a << 1;
         bits_a <= bits_a - 1;
         if (bits_a == 1) begin
            cs_r_a     <= 1'b1;
            rx_valid_a <= 1'b1;
            rx_word_a  <= {rx_a[22:0], sh_a[23]};
         end
      end else if (ser_en_a && send_a) begin
         sh_a   <= pattern_a;
         bits_a <= 24;
         cs_r_a <= 1'b0;
      end
   end

   always @(posedge clk) begin
      rx_valid_b <= 1'b0;
      if (bits_b != 0) begin
         rx_b   <= {rx_b[22:0], sh_b[23]};
         sh_b   <= sh_b << 1;
         bits_b <= bits_b - 1;
         if (bits_b == 1) begin
            cs_r_b     <= 1'b1;
            rx_valid_b <= 1'b1;
            rx_word_b  <= {rx_b[22:0], sh_b[23]};
         end
      end else if (send_b) begin
         sh_b   <= pattern_b;
         bits_b <= 24;
         cs_r_b <= 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: counts sends, checks cs at each send, scoreboards received words.
   int send_cnt_a = 0, send_cnt_b = 0;
   always @(negedge clk) begin
      if (send_a) begin
         send_cnt_a++;
         check("a_send_with_cs_high", cs_a, 1);
      end
      if (send_b) begin
         send_cnt_b++;
         check("b_send_with_cs_high", cs_b, 1);
      end
      if (rx_valid_a) begin
         if (exp_a.size() == 0) check("a_rx_unexpected_word", rx_word_a, 32'hFFFF_FFFF);
         else check("a_rx_word", rx_word_a, exp_a.pop_front());
      end
      if (rx_valid_b) begin
         if (exp_b.size() == 0) check("b_rx_unexpected_word", rx_word_b, 32'hFFFF_FFFF);
         else check("b_rx_word", rx_word_b, exp_b.pop_front());
      end
   end

   function automatic logic sig(input int which);
      case (which)
         0:       return send_a;
         1:       return done_a;
         2:       return err_a;
         3:       return send_b;
         default: return done_b;
      endcase
   endfunction

   // Bounded wait for a DUT output to be high at a falling edge.
   task automatic wait_hi(input int which, input int budget, input string name, output int t);
      int n = 0;
      t = -1;
      while (n < budget) begin
         @(negedge clk);
         n++;
         if (sig(which)) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) check({name, "_timeout"}, 0, 1);
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: time limit reached before the bench completed");
      $fatal(1, "watchdog expired");
   end

   int t_start, t_s0, t_s1, t_s2, t_done, t_rel, base;
   logic saw;

   initial begin
      // Reset held with start asserted: reset must dominate.
      start_a = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_send",    send_a,    0);
      check("rst_pattern", pattern_a, 0);
      check("rst_busy",    busy_a,    0);
      check("rst_done",    done_a,    0);
      check("rst_err",     err_a,     0);
      check("rst_idx",     idx_a,     0);
      check("rst_b_busy",  busy_b,    0);
      rst = 1'b0;
      start_a = 1'b0;
      repeat (2) @(negedge clk);

      // Full 3-word run: latency, spacing, words, completion.
      foreach (exp_rom[i]) exp_a.push_back(exp_rom[i]);
      start_a = 1'b1;
      t_start = cyc;
      @(negedge clk);
      start_a = 1'b0;
      check("start_busy", busy_a, 1);
      wait_hi(0, 40, "send0", t_s0);
      check("first_send_latency", t_s0 - t_start - 1, 11);
      check("send0_pattern", pattern_a, exp_rom[0]);
      wait_hi(0, 60, "send1", t_s1);
      check("spacing_0_1", t_s1 - t_s0, 31);
      check("send1_idx", idx_a, 1);
      wait_hi(0, 60, "send2", t_s2);
      check("spacing_1_2", t_s2 - t_s1, 31);
      wait_hi(1, 80, "done_run1", t_done);
      check("run1_busy", busy_a, 0);
      check("run1_idx", idx_a, 2);
      repeat (20) @(negedge clk);
      check("run1_sends", send_cnt_a, 3);
      check("run1_queue_empty", exp_a.size(), 0);

      // Start held high during busy: ignored; start after done restarts at word 0.
      base = send_cnt_a;
      foreach (exp_rom[i]) exp_a.push_back(exp_rom[i]);
      start_a = 1'b1;
      @(negedge clk);
      check("restart_done_cleared", done_a, 0);
      check("restart_busy", busy_a, 1);
      check("restart_idx", idx_a, 0);
      repeat (60) @(negedge clk);
      start_a = 1'b0;
      wait_hi(1, 150, "done_run2", t_done);
      repeat (20) @(negedge clk);
      check("run2_sends", send_cnt_a - base, 3);

      // Reset 10 cycles into word 1, then restart with cs held low.
      base = send_cnt_a;
      exp_a.push_back(exp_rom[0]);
      exp_a.push_back(exp_rom[1]);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      wait_hi(0, 40, "rst_run_send0", t_s0);
      wait_hi(0, 60, "rst_run_send1", t_s1);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      hold_low_a = 1'b1;
      @(negedge clk);
      check("midrst_send",    send_a,    0);
      check("midrst_pattern", pattern_a, 0);
      check("midrst_busy",    busy_a,    0);
      check("midrst_done",    done_a,    0);
      check("midrst_err",     err_a,     0);
      check("midrst_idx",     idx_a,     0);
      rst = 1'b0;
      foreach (exp_rom[i]) exp_a.push_back(exp_rom[i]);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      saw = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (send_a) saw = 1'b1;
      end
      check("no_send_while_cs_low", saw, 0);
      check("cs_low_still_busy", busy_a, 1);
      hold_low_a = 1'b0;
      t_rel = cyc;
      wait_hi(0, 5, "send_after_cs_release", t_s0);
      check("send_after_release_delay", t_s0 - t_rel, 1);
      wait_hi(1, 150, "done_run3", t_done);
      repeat (20) @(negedge clk);
      check("run3_sends", send_cnt_a - base, 5);
      check("run3_queue_empty", exp_a.size(), 0);

      // Acknowledge timeout: cs tied high.
      ser_en_a = 1'b0;
      base = send_cnt_a;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      wait_hi(0, 40, "timeout_send", t_s0);
      repeat (4) @(negedge clk);
      check("err_not_early", err_a, 0);
      @(negedge clk);
      check("err_after_timeout", err_a, 1);
      check("err_busy", busy_a, 0);
      check("err_done", done_a, 0);
      repeat (40) @(negedge clk);
      check("timeout_single_send", send_cnt_a - base, 1);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      check("err_cleared_by_start", err_a, 0);
      check("err_restart_busy", busy_a, 1);
      wait_hi(2, 40, "err_again", t_done);
      ser_en_a = 1'b1;

      // Single word, no power-up, no gap.
      exp_b.push_back(exp_rom[0]);
      start_b = 1'b1;
      t_start = cyc;
      @(negedge clk);
      start_b = 1'b0;
      wait_hi(3, 10, "b_send", t_s0);
      check("b_send_latency", t_s0 - t_start - 1, 2);
      check("b_send_idx", idx_b, 0);
      wait_hi(4, 60, "b_done", t_done);
      check("b_done_latency", t_done - t_s0, 26);
      check("b_done_idx", idx_b, 0);
      check("b_done_busy", busy_b, 0);
      check("b_done_cs_high", cs_b, 1);
      repeat (5) @(negedge clk);
      check("b_sends", send_cnt_b, 1);
      check("b_queue_empty", exp_b.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
